// File: rtl/labs_find_pkg.sv
// rtl/labs_find_pkg.sv - shared constants and state type for the LABS search engine
package labs_find_pkg;

  localparam int E_WIDTH = 20;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/labs_corr_sq.sv
// rtl/labs_corr_sq.sv - combinational squared aperiodic autocorrelation C_k^2 of x at lag k
import labs_find_pkg::*;

module labs_corr_sq #(
  parameter int SEQ_WIDTH = 16,
  parameter int KW        = $clog2(SEQ_WIDTH)
) (
  input  logic [SEQ_WIDTH-1:0] x,
  input  logic [KW-1:0]        k,
  output logic [E_WIDTH-1:0]   csq
);

  logic [SEQ_WIDTH-1:0] diff;
  int                   pop;
  int                   c;

  // Each mismatching pair s_i != s_{i+k} contributes -1 instead of +1.
  always_comb begin
    diff = (x ^ (x >> k)) & ({SEQ_WIDTH{1'b1}} >> k);
    pop  = 0;
    for (int i = 0; i < SEQ_WIDTH; i++) begin
      pop = pop + int'(diff[i]);
    end
    c   = (SEQ_WIDTH - int'(k)) - 2 * pop;
    csq = E_WIDTH'(c * c);
  end

endmodule

// File: rtl/labs_find.sv
// rtl/labs_find.sv - exhaustive LABS search: one lag per cycle, keeps lowest-energy sequence
import labs_find_pkg::*;

module labs_find #(
  parameter int SEQ_WIDTH = 16,
  parameter int FIX_WIDTH = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           i_offset,
  output logic [SEQ_WIDTH-1:0] o_seq,
  output logic [E_WIDTH-1:0]   o_e,
  output logic                 o_done
);

  localparam int             CNT_W    = SEQ_WIDTH - FIX_WIDTH;
  localparam int             KW       = $clog2(SEQ_WIDTH);
  localparam logic [KW-1:0]  K_LAST   = KW'(SEQ_WIDTH - 1);
  localparam logic [6:0]     FIX_MASK = 7'((1 << FIX_WIDTH) - 1);

  state_t               state;
  logic [SEQ_WIDTH-1:0] prefix;
  logic [CNT_W-1:0]     cnt;
  logic [KW-1:0]        k;
  logic [E_WIDTH-1:0]   acc;
  logic [E_WIDTH-1:0]   csq;
  logic [E_WIDTH-1:0]   e_sum;
  logic [SEQ_WIDTH-1:0] x;

  assign x     = prefix | SEQ_WIDTH'(cnt);
  assign e_sum = acc + csq;

  labs_corr_sq #(
    .SEQ_WIDTH (SEQ_WIDTH),
    .KW        (KW)
  ) u_corr_sq (
    .x   (x),
    .k   (k),
    .csq (csq)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= INIT;
      prefix <= '0;
      cnt    <= '0;
      k      <= '0;
      acc    <= '0;
      o_seq  <= '0;
      o_e    <= '1;
      o_done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          // With no fixed bits the offset seeds the counter instead of the prefix.
          prefix <= SEQ_WIDTH'(i_offset & FIX_MASK) << CNT_W;
          cnt    <= (FIX_WIDTH == 0) ? CNT_W'(i_offset) : '0;
          k      <= KW'(1);
          acc    <= '0;
          state  <= EVAL;
        end
        EVAL: begin
          if (k == K_LAST) begin
            // Strict compare keeps the earliest (lowest) candidate on ties.
            if (e_sum < o_e) begin
              o_seq <= x;
              o_e   <= e_sum;
            end
            if (&cnt) begin
              state  <= DONE;
              o_done <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
              k   <= KW'(1);
              acc <= '0;
            end
          end else begin
            acc <= e_sum;
            k   <= k + KW'(1);
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_labs_find.sv
// tb/tb_labs_find.sv - directed self-checking bench for labs_find
module tb_labs_find;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  logic        rst4a, rst4b, rst8, rst16;
  logic [6:0]  off4a, off4b, off8, off16;
  logic [3:0]  seq4a, seq4b;
  logic [7:0]  seq8;
  logic [15:0] seq16;
  logic [19:0] e4a, e4b, e8, e16;
  logic        done4a, done4b, done8, done16;

  labs_find #(.SEQ_WIDTH(4), .FIX_WIDTH(0)) dut4a (
    .clk(clk), .rst(rst4a), .i_offset(off4a), .o_seq(seq4a), .o_e(e4a), .o_done(done4a));
  labs_find #(.SEQ_WIDTH(4), .FIX_WIDTH(2)) dut4b (
    .clk(clk), .rst(rst4b), .i_offset(off4b), .o_seq(seq4b), .o_e(e4b), .o_done(done4b));
  labs_find #(.SEQ_WIDTH(8), .FIX_WIDTH(0)) dut8 (
    .clk(clk), .rst(rst8), .i_offset(off8), .o_seq(seq8), .o_e(e8), .o_done(done8));
  labs_find #(.SEQ_WIDTH(16), .FIX_WIDTH(7)) dut16 (
    .clk(clk), .rst(rst16), .i_offset(off16), .o_seq(seq16), .o_e(e16), .o_done(done16));

  // Direct definition: C_k = sum s_i*s_{i+k}, s = +1 for bit 1, -1 for bit 0.
  function automatic int model_e(input int n, input logic [63:0] x);
    int e;
    e = 0;
    for (int k = 1; k < n; k++) begin
      int c;
      c = 0;
      for (int i = 0; i < n - k; i++) c += (x[i] == x[i+k]) ? 1 : -1;
      e += c * c;
    end
    return e;
  endfunction

  task automatic model_best(input int n, input longint lo, input longint hi,
                            output longint bx, output int be);
    be = 32'hFFFFF;
    bx = 0;
    for (longint x = lo; x <= hi; x++) begin
      int e;
      e = model_e(n, 64'(x));
      if (e < be) begin
        be = e;
        bx = x;
      end
    end
  endtask

  // Waits for dut8 to finish while checking every o_e update against the model.
  task automatic wait_done8(input int limit, output int cyc);
    logic [19:0] prev;
    prev = 20'hFFFFF;
    cyc  = 0;
    while (done8 !== 1'b1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (e8 !== prev) begin
        total++;
        if (e8 < prev && int'(e8) == model_e(8, 64'(seq8))) passed++;
        else $display("FAIL sb_n8: o_e=%0d prev=%0d model(o_seq=%h)=%0d",
                      e8, prev, seq8, model_e(8, 64'(seq8)));
        prev = e8;
      end
    end
    total++;
    if (done8 !== 1'b1) $display("FAIL n8_timeout: o_done=%b after %0d cycles, required 1", done8, cyc);
    else passed++;
  endtask

  task automatic test_reset();
    rst4a = 1'b0; rst4b = 1'b0; rst8 = 1'b0; rst16 = 1'b0;
    off4a = '0; off4b = '0; off8 = '0; off16 = '0;
    repeat (2) @(negedge clk);
    total++; if (seq8 !== 8'h00) $display("FAIL reset_seq8: got %h required 00", seq8); else passed++;
    total++; if (e8 !== 20'hFFFFF) $display("FAIL reset_e8: got %h required FFFFF", e8); else passed++;
    total++; if (done8 !== 1'b0) $display("FAIL reset_done8: got %b required 0", done8); else passed++;
    total++; if (e16 !== 20'hFFFFF) $display("FAIL reset_e16: got %h required FFFFF", e16); else passed++;
    total++; if (done4a !== 1'b0 || done4b !== 1'b0)
      $display("FAIL reset_done4: got %b%b required 00", done4a, done4b); else passed++;
  endtask

  task automatic test_n4_full();
    off4a = 7'd0;
    @(negedge clk);
    rst4a = 1'b1;
    repeat (48) @(negedge clk);
    total++; if (done4a !== 1'b0) $display("FAIL n4_early_done: got %b required 0 at cycle 48", done4a); else passed++;
    @(negedge clk);
    total++; if (done4a !== 1'b1) $display("FAIL n4_done49: got %b required 1 at cycle 49", done4a); else passed++;
    total++; if (seq4a !== 4'b0001) $display("FAIL n4_seq: got %b required 0001", seq4a); else passed++;
    total++; if (e4a !== 20'd2) $display("FAIL n4_e: got %0d required 2", e4a); else passed++;
  endtask

  task automatic test_n4_fixed();
    off4b = 7'd2;
    @(negedge clk);
    rst4b = 1'b1;
    repeat (12) @(negedge clk);
    total++; if (done4b !== 1'b0) $display("FAIL n4fix_early_done: got %b required 0 at cycle 12", done4b); else passed++;
    @(negedge clk);
    total++; if (done4b !== 1'b1) $display("FAIL n4fix_done13: got %b required 1 at cycle 13", done4b); else passed++;
    total++; if (seq4b !== 4'b1000) $display("FAIL n4fix_seq: got %b required 1000", seq4b); else passed++;
    total++; if (e4b !== 20'd2) $display("FAIL n4fix_e: got %0d required 2", e4b); else passed++;
  endtask

  task automatic test_n8_full();
    int cyc;
    longint bx;
    int be;
    model_best(8, 0, 255, bx, be);
    off8 = 7'd0;
    @(negedge clk);
    rst8 = 1'b1;
    wait_done8(3000, cyc);
    total++; if (cyc != 1793) $display("FAIL n8_latency: got %0d required 1793", cyc); else passed++;
    total++; if (e8 !== 20'd8) $display("FAIL n8_e_opt: got %0d required 8", e8); else passed++;
    total++; if (int'(e8) != be) $display("FAIL n8_e_model: got %0d required %0d", e8, be); else passed++;
    total++; if (seq8 !== 8'(bx)) $display("FAIL n8_seq: got %h required %h", seq8, 8'(bx)); else passed++;
  endtask

  task automatic test_n8_offset();
    int cyc;
    longint bx;
    int be;
    model_best(8, 6, 255, bx, be);
    @(negedge clk);
    rst8 = 1'b0;
    off8 = 7'd6;
    @(negedge clk);
    rst8 = 1'b1;
    repeat (10) @(negedge clk);
    off8 = 7'd0;
    wait_done8(3000, cyc);
    total++; if (cyc + 10 != 1751) $display("FAIL n8off_latency: got %0d required 1751", cyc + 10); else passed++;
    total++; if (e8 !== 20'd8) $display("FAIL n8off_e: got %0d required 8", e8); else passed++;
    total++; if (seq8 !== 8'(bx)) $display("FAIL n8off_seq: got %h required %h", seq8, 8'(bx)); else passed++;
  endtask

  task automatic test_abort();
    int cyc;
    longint bx;
    int be;
    model_best(8, 0, 255, bx, be);
    @(negedge clk);
    rst8 = 1'b0;
    off8 = 7'd0;
    @(negedge clk);
    rst8 = 1'b1;
    repeat (200) @(negedge clk);
    total++; if (e8 === 20'hFFFFF) $display("FAIL abort_pre_e: got %h required below FFFFF", e8); else passed++;
    #2 rst8 = 1'b0;
    #1;
    total++; if (done8 !== 1'b0) $display("FAIL abort_done: got %b required 0", done8); else passed++;
    total++; if (e8 !== 20'hFFFFF) $display("FAIL abort_e: got %h required FFFFF", e8); else passed++;
    total++; if (seq8 !== 8'h00) $display("FAIL abort_seq: got %h required 00", seq8); else passed++;
    @(negedge clk);
    rst8 = 1'b1;
    wait_done8(3000, cyc);
    total++; if (cyc != 1793) $display("FAIL abort_latency: got %0d required 1793", cyc); else passed++;
    total++; if (seq8 !== 8'(bx) || int'(e8) != be)
      $display("FAIL abort_result: got %h/%0d required %h/%0d", seq8, e8, 8'(bx), be); else passed++;
  endtask

  task automatic test_n16_fixed();
    int cyc;
    longint lo;
    longint bx;
    int be;
    lo = longint'(7'h2A) << 9;
    model_best(16, lo, lo + 511, bx, be);
    off16 = 7'h2A;
    @(negedge clk);
    rst16 = 1'b1;
    cyc = 0;
    while (done16 !== 1'b1 && cyc < 9000) begin
      @(negedge clk);
      cyc++;
    end
    total++; if (done16 !== 1'b1) $display("FAIL n16_timeout: o_done=%b after %0d cycles", done16, cyc); else passed++;
    total++; if (cyc != 7681) $display("FAIL n16_latency: got %0d required 7681", cyc); else passed++;
    total++; if (int'(e16) != be) $display("FAIL n16_e: got %0d required %0d", e16, be); else passed++;
    total++; if (seq16 !== 16'(bx)) $display("FAIL n16_seq: got %h required %h", seq16, 16'(bx)); else passed++;
  endtask

  initial begin
    test_reset();
    test_n4_full();
    test_n4_fixed();
    test_n8_full();
    test_n8_offset();
    test_abort();
    test_n16_fixed();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
